// File: rtl/lcd1602_reader.sv
// lcd1602_reader
//
// Read-side bus sequencer for an HD44780-compatible 1602 character panel.
// Performs a single status read (RS=0), a single data read (RS=1), or a
// busy-poll that repeats status reads until the busy flag (bit 7) clears
// or POLL_MAX reads have been made.
//
// Ports
//   Clk            system clock, rising edge
//   Rst_n          asynchronous active-low reset
//   rd_status      request a status read (BF in bit 7, address counter in 6:0)
//   rd_data        request a data read from DDRAM/CGRAM
//   poll_busy      request repeated status reads until BF=0 or timeout
//   LCD1602_DB_IN  data bus value driven by the panel while RW=1
//   rd_busy        high while a transaction is in progress
//   rd_done        one-cycle completion pulse
//   rd_value       last sampled bus value
//   busy_timeout   one-cycle pulse with rd_done when a poll runs out of reads
//   LCD1602_RS     register select (0 = instruction/status, 1 = data)
//   LCD1602_RW     read/write (1 = read); 0 whenever idle
//   LCD1602_E      enable strobe
//
// Request priority in idle is poll_busy > rd_status > rd_data. Requests
// that arrive while a transaction is running are dropped.

module lcd1602_reader #(
  parameter int unsigned SETUP_CYC  = 2,   // RS/RW settle cycles before E rises
  parameter int unsigned E_HIGH_CYC = 11,  // cycles E is held high
  parameter int unsigned E_LOW_CYC  = 16,  // cycles E is held low after the fall
  parameter int unsigned POLL_MAX   = 255  // max status reads per poll, 1..255
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       rd_status,
  input  logic       rd_data,
  input  logic       poll_busy,
  input  logic [7:0] LCD1602_DB_IN,
  output logic       rd_busy,
  output logic       rd_done,
  output logic [7:0] rd_value,
  output logic       busy_timeout,
  output logic       LCD1602_RS,
  output logic       LCD1602_RW,
  output logic       LCD1602_E
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StSetE  = 3'd2,
    StEHigh = 3'd3,
    StClrE  = 3'd4,
    StHold  = 3'd5,
    StCheck = 3'd6
  } state_e;

  // Cycle counter value on the final cycle of each timed state.
  localparam logic [7:0] SetupLast = 8'(SETUP_CYC - 1);
  localparam logic [7:0] EHighLast = 8'(E_HIGH_CYC - 1);
  localparam logic [7:0] ELowLast  = 8'(E_LOW_CYC - 1);
  localparam logic [8:0] PollMax   = 9'(POLL_MAX);

  state_e     state_q, state_d;
  logic [7:0] cyc_q, cyc_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic       is_poll_q, is_poll_d;
  logic [7:0] rd_value_q, rd_value_d;
  logic       rs_q, rs_d;
  logic       rw_q, rw_d;
  logic       e_q, e_d;

  logic       req_any;
  logic       accept;
  logic       still_busy;
  logic       poll_more;
  logic       poll_exhausted;

  assign req_any = poll_busy | rd_status | rd_data;
  assign accept  = (state_q == StIdle) && req_any;

  // Panel still reports BF=1 on a poll; decide whether another read fits.
  // The 9-bit sum keeps counter+1 from wrapping when POLL_MAX is 255.
  assign still_busy     = is_poll_q && rd_value_q[7];
  assign poll_more      = still_busy && (({1'b0, poll_cnt_q} + 9'd1) < PollMax);
  assign poll_exhausted = still_busy && !poll_more;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_any) state_d = StSetup;
      end
      StSetup: begin
        if (cyc_q == SetupLast) state_d = StSetE;
      end
      StSetE: begin
        state_d = StEHigh;
      end
      StEHigh: begin
        if (cyc_q == EHighLast) state_d = StClrE;
      end
      StClrE: begin
        state_d = StHold;
      end
      StHold: begin
        if (cyc_q == ELowLast) state_d = StCheck;
      end
      StCheck: begin
        // Re-poll keeps RS/RW as they are and goes straight back to setup.
        state_d = poll_more ? StSetup : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // Panel lines are registered off the next state so they change cleanly on
  // the clock edge: E is high exactly for the E_HIGH cycles, RW is high for
  // every non-idle cycle, and RS is loaded only when a request is accepted.
  always_comb begin
    rs_d = rs_q;
    if (accept) begin
      rs_d = !poll_busy && !rd_status;
    end
    rw_d = (state_d != StIdle);
    e_d  = (state_d == StEHigh);

    rd_busy      = (state_q != StIdle);
    rd_done      = (state_q == StCheck) && !poll_more;
    busy_timeout = (state_q == StCheck) && poll_exhausted;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rs_q <= 1'b0;
      rw_q <= 1'b0;
      e_q  <= 1'b0;
    end else begin
      rs_q <= rs_d;
      rw_q <= rw_d;
      e_q  <= e_d;
    end
  end

  assign LCD1602_RS = rs_q;
  assign LCD1602_RW = rw_q;
  assign LCD1602_E  = e_q;
  assign rd_value   = rd_value_q;

  // ---------------------------------------------------------------------------
  // Counters and captured data
  // ---------------------------------------------------------------------------
  always_comb begin
    // Cycle counter restarts on every state change and rests at zero in idle.
    if ((state_d != state_q) || (state_q == StIdle)) begin
      cyc_d = 8'd0;
    end else begin
      cyc_d = cyc_q + 8'd1;
    end

    is_poll_d = is_poll_q;
    if (accept) begin
      is_poll_d = poll_busy;
    end

    poll_cnt_d = poll_cnt_q;
    if (accept) begin
      poll_cnt_d = 8'd0;
    end else if ((state_q == StCheck) && poll_more) begin
      poll_cnt_d = poll_cnt_q + 8'd1;
    end

    // Sample on the last E-high cycle; E falls on this same edge.
    rd_value_d = rd_value_q;
    if ((state_q == StEHigh) && (cyc_q == EHighLast)) begin
      rd_value_d = LCD1602_DB_IN;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cyc_q      <= 8'd0;
      poll_cnt_q <= 8'd0;
      is_poll_q  <= 1'b0;
      rd_value_q <= 8'h00;
    end else begin
      cyc_q      <= cyc_d;
      poll_cnt_q <= poll_cnt_d;
      is_poll_q  <= is_poll_d;
      rd_value_q <= rd_value_d;
    end
  end

endmodule
